// File: rtl/cm0_sleep_power_ctrl.sv
// rtl/cm0_sleep_power_ctrl.sv - Cortex-M0 sleep/deep-sleep handshake, HCLK gating and PMU retention sequencer
module cm0_sleep_power_ctrl #(
    parameter int unsigned GATE_DLY = 4,
    parameter int unsigned HOLD_TMO = 16,
    parameter bit          WIC_MODE = 1'b1
) (
    input  logic       SCLK,
    input  logic       HRESET,
    input  logic       SLEEPING,
    input  logic       SLEEPDEEP,
    input  logic       SLEEPHOLDACKn,
    input  logic       WICDSACKn,
    input  logic       WAKEUP,
    input  logic       DBGKEEP,
    input  logic       PMUPWRUPACK,
    output logic       SLEEPHOLDREQn,
    output logic       WICDSREQn,
    output logic       HCLKEN,
    output logic       PMUPWRDNREQ,
    output logic       ISOLATE,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_GWAIT   = 3'd1,
        ST_LSLEEP  = 3'd2,
        ST_DSREQ   = 3'd3,
        ST_DSGATED = 3'd4,
        ST_PWRDN   = 3'd5,
        ST_PWRUP   = 3'd6,
        ST_RESTORE = 3'd7
    } state_e;

    localparam logic [7:0] GATE_LOAD = 8'(GATE_DLY - 1);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_TMO - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       hclken_q, hclken_d;
    logic       holdreq_n_q, holdreq_n_d;
    logic       pwrdnreq_q, pwrdnreq_d;
    logic       isolate_q, isolate_d;
    logic       wicdsreq_n_q;

    // One counter serves both the gate delay (GWAIT) and the hold-ack timeout (DSREQ).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (!DBGKEEP && SLEEPING) begin
                    if (SLEEPDEEP) begin
                        state_d = ST_DSREQ;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = ST_GWAIT;
                        cnt_d   = GATE_LOAD;
                    end
                end
            end
            ST_GWAIT: begin
                if (!SLEEPING || DBGKEEP) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == 8'd0) begin
                    state_d = ST_LSLEEP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_LSLEEP: begin
                if (!SLEEPING || WAKEUP || DBGKEEP) begin
                    state_d = ST_RUN;
                end
            end
            ST_DSREQ: begin
                if (!SLEEPING || DBGKEEP) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (!SLEEPHOLDACKn) begin
                    state_d = (WIC_MODE && !WICDSACKn) ? ST_PWRDN : ST_DSGATED;
                    cnt_d   = '0;
                end else if (cnt_q == 8'd0) begin
                    state_d = ST_GWAIT;
                    cnt_d   = GATE_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DSGATED: begin
                if (WAKEUP || DBGKEEP) begin
                    state_d = ST_RESTORE;
                end
            end
            ST_PWRDN: begin
                if (WAKEUP || DBGKEEP) begin
                    state_d = ST_PWRUP;
                end
            end
            ST_PWRUP: begin
                if (PMUPWRUPACK) begin
                    state_d = ST_RESTORE;
                end
            end
            ST_RESTORE: begin
                if (SLEEPHOLDACKn) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as STATE.
    always_comb begin
        hclken_d    = 1'b1;
        holdreq_n_d = 1'b1;
        isolate_d   = 1'b0;
        pwrdnreq_d  = 1'b0;
        if (state_d inside {ST_LSLEEP, ST_DSGATED, ST_PWRDN, ST_PWRUP}) begin
            hclken_d = 1'b0;
        end
        if (state_d inside {ST_DSREQ, ST_DSGATED, ST_PWRDN, ST_PWRUP}) begin
            holdreq_n_d = 1'b0;
        end
        if (state_d inside {ST_PWRDN, ST_PWRUP}) begin
            isolate_d = 1'b1;
        end
        // PMU request trails isolation by one cycle so clamps settle before power drops.
        if ((state_q == ST_PWRDN) && (state_d == ST_PWRDN)) begin
            pwrdnreq_d = 1'b1;
        end
    end

    always_ff @(posedge SCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            hclken_q     <= 1'b1;
            holdreq_n_q  <= 1'b1;
            pwrdnreq_q   <= 1'b0;
            isolate_q    <= 1'b0;
            wicdsreq_n_q <= ~WIC_MODE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hclken_q     <= hclken_d;
            holdreq_n_q  <= holdreq_n_d;
            pwrdnreq_q   <= pwrdnreq_d;
            isolate_q    <= isolate_d;
            wicdsreq_n_q <= ~WIC_MODE;
        end
    end

    assign SLEEPHOLDREQn = holdreq_n_q;
    assign WICDSREQn     = wicdsreq_n_q;
    assign HCLKEN        = hclken_q;
    assign PMUPWRDNREQ   = pwrdnreq_q;
    assign ISOLATE       = isolate_q;
    assign STATE         = state_q;

endmodule

// File: tb/tb_cm0_sleep_power_ctrl.sv
// tb/tb_cm0_sleep_power_ctrl.sv - self-checking bench for cm0_sleep_power_ctrl
module tb_cm0_sleep_power_ctrl;

    localparam int GATE_DLY = 4;
    localparam int HOLD_TMO = 16;
    localparam bit WIC_MODE = 1'b1;

    logic       SCLK          = 1'b0;
    logic       HRESET        = 1'b1;
    logic       SLEEPING      = 1'b0;
    logic       SLEEPDEEP     = 1'b0;
    logic       SLEEPHOLDACKn = 1'b1;
    logic       WICDSACKn     = 1'b1;
    logic       WAKEUP        = 1'b0;
    logic       DBGKEEP       = 1'b0;
    logic       PMUPWRUPACK   = 1'b0;
    logic       SLEEPHOLDREQn;
    logic       WICDSREQn;
    logic       HCLKEN;
    logic       PMUPWRDNREQ;
    logic       ISOLATE;
    logic [2:0] STATE;

    int n_chk  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;
    int m_st   = 0;
    int m_age  = 0;

    cm0_sleep_power_ctrl #(
        .GATE_DLY(GATE_DLY),
        .HOLD_TMO(HOLD_TMO),
        .WIC_MODE(WIC_MODE)
    ) dut (
        .SCLK(SCLK),
        .HRESET(HRESET),
        .SLEEPING(SLEEPING),
        .SLEEPDEEP(SLEEPDEEP),
        .SLEEPHOLDACKn(SLEEPHOLDACKn),
        .WICDSACKn(WICDSACKn),
        .WAKEUP(WAKEUP),
        .DBGKEEP(DBGKEEP),
        .PMUPWRUPACK(PMUPWRUPACK),
        .SLEEPHOLDREQn(SLEEPHOLDREQn),
        .WICDSREQn(WICDSREQn),
        .HCLKEN(HCLKEN),
        .PMUPWRDNREQ(PMUPWRDNREQ),
        .ISOLATE(ISOLATE),
        .STATE(STATE)
    );

    always #5 SCLK = ~SCLK;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: state number plus cycles spent in it; outputs are pure functions of that.
    function automatic int model_next(input int st, input int age);
        case (st)
            0: begin
                if (DBGKEEP || !SLEEPING) return 0;
                return SLEEPDEEP ? 3 : 1;
            end
            1: begin
                if (!SLEEPING || DBGKEEP) return 0;
                return (age >= GATE_DLY - 1) ? 2 : 1;
            end
            2: return (!SLEEPING || WAKEUP || DBGKEEP) ? 0 : 2;
            3: begin
                if (!SLEEPING || DBGKEEP) return 0;
                if (!SLEEPHOLDACKn) return (WIC_MODE && !WICDSACKn) ? 5 : 4;
                return (age >= HOLD_TMO - 1) ? 1 : 3;
            end
            4: return (WAKEUP || DBGKEEP) ? 7 : 4;
            5: return (WAKEUP || DBGKEEP) ? 6 : 5;
            6: return PMUPWRUPACK ? 7 : 6;
            default: return SLEEPHOLDACKn ? 0 : 7;
        endcase
    endfunction

    always @(posedge SCLK or posedge HRESET) begin
        if (HRESET) begin
            m_st  <= 0;
            m_age <= 0;
        end else begin
            m_st  <= model_next(m_st, m_age);
            m_age <= (model_next(m_st, m_age) == m_st) ? m_age + 1 : 0;
        end
    end

    always @(negedge SCLK) begin
        if (chk_en) begin
            chk("cmp_STATE", int'(STATE), m_st);
            chk("cmp_HCLKEN", int'(HCLKEN), (m_st == 2 || m_st == 4 || m_st == 5 || m_st == 6) ? 0 : 1);
            chk("cmp_ISOLATE", int'(ISOLATE), (m_st == 5 || m_st == 6) ? 1 : 0);
            chk("cmp_SLEEPHOLDREQn", int'(SLEEPHOLDREQn), (m_st >= 3 && m_st <= 6) ? 0 : 1);
            chk("cmp_PMUPWRDNREQ", int'(PMUPWRDNREQ), (m_st == 5 && m_age >= 1) ? 1 : 0);
            chk("cmp_WICDSREQn", int'(WICDSREQn), WIC_MODE ? 0 : 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge SCLK);
        #2;
    endtask

    task automatic idle_inputs();
        SLEEPING      = 1'b0;
        SLEEPDEEP     = 1'b0;
        SLEEPHOLDACKn = 1'b1;
        WICDSACKn     = 1'b1;
        WAKEUP        = 1'b0;
        DBGKEEP       = 1'b0;
        PMUPWRUPACK   = 1'b0;
    endtask

    initial begin
        idle_inputs();
        HRESET = 1'b1;
        tick(2);
        HRESET = 1'b0;
        chk_en = 1'b1;
        tick(1);
        chk("rst_STATE", int'(STATE), 0);
        chk("rst_HCLKEN", int'(HCLKEN), 1);
        chk("rst_SLEEPHOLDREQn", int'(SLEEPHOLDREQn), 1);
        chk("rst_PMUPWRDNREQ", int'(PMUPWRDNREQ), 0);
        chk("rst_ISOLATE", int'(ISOLATE), 0);
        chk("rst_WICDSREQn", int'(WICDSREQn), 0);

        // Light sleep: gated exactly GATE_DLY cycles after GWAIT entry.
        SLEEPING = 1'b1;
        tick(1);
        chk("ls_enter_gwait", int'(STATE), 1);
        tick(3);
        chk("ls_still_running", int'(HCLKEN), 1);
        chk("ls_pin_model_gwait", m_st, 1);
        tick(1);
        chk("ls_gated", int'(HCLKEN), 0);
        chk("ls_state_lsleep", int'(STATE), 2);
        chk("ls_pin_model_lsleep", m_st, 2);
        tick(3);
        SLEEPING = 1'b0;
        tick(1);
        chk("ls_wake_hclken", int'(HCLKEN), 1);
        chk("ls_wake_state", int'(STATE), 0);

        // Light-sleep abort after two cycles.
        SLEEPING = 1'b1;
        tick(2);
        chk("ab_gwait", int'(STATE), 1);
        SLEEPING = 1'b0;
        tick(1);
        chk("ab_run", int'(STATE), 0);
        chk("ab_hclken", int'(HCLKEN), 1);

        // WIC power-down and restore.
        SLEEPING  = 1'b1;
        SLEEPDEEP = 1'b1;
        tick(1);
        chk("pd_holdreq", int'(SLEEPHOLDREQn), 0);
        chk("pd_dsreq", int'(STATE), 3);
        tick(2);
        SLEEPHOLDACKn = 1'b0;
        WICDSACKn     = 1'b0;
        tick(1);
        chk("pd_state", int'(STATE), 5);
        chk("pd_isolate", int'(ISOLATE), 1);
        chk("pd_hclken", int'(HCLKEN), 0);
        chk("pd_req_not_yet", int'(PMUPWRDNREQ), 0);
        tick(1);
        chk("pd_req", int'(PMUPWRDNREQ), 1);
        WAKEUP = 1'b1;
        tick(1);
        chk("pu_state", int'(STATE), 6);
        chk("pu_req_off", int'(PMUPWRDNREQ), 0);
        chk("pu_isolate", int'(ISOLATE), 1);
        WAKEUP      = 1'b0;
        SLEEPING    = 1'b0;
        SLEEPDEEP   = 1'b0;
        PMUPWRUPACK = 1'b1;
        tick(1);
        chk("rs_state", int'(STATE), 7);
        chk("rs_isolate", int'(ISOLATE), 0);
        chk("rs_hclken", int'(HCLKEN), 1);
        chk("rs_holdreq", int'(SLEEPHOLDREQn), 1);
        idle_inputs();
        tick(1);
        chk("rs_run", int'(STATE), 0);

        // Hold-ack timeout falls back to light sleep.
        SLEEPING  = 1'b1;
        SLEEPDEEP = 1'b1;
        tick(16);
        chk("to_dsreq", int'(STATE), 3);
        chk("to_holdreq_low", int'(SLEEPHOLDREQn), 0);
        tick(1);
        chk("to_gwait", int'(STATE), 1);
        chk("to_holdreq_high", int'(SLEEPHOLDREQn), 1);
        tick(3);
        chk("to_not_gated", int'(HCLKEN), 1);
        tick(1);
        chk("to_gated", int'(HCLKEN), 0);
        idle_inputs();
        tick(1);
        chk("to_run", int'(STATE), 0);

        // Debug override in PWRDN, indefinite PWRUP wait, then async reset.
        SLEEPING  = 1'b1;
        SLEEPDEEP = 1'b1;
        tick(1);
        SLEEPHOLDACKn = 1'b0;
        WICDSACKn     = 1'b0;
        tick(1);
        chk("dbg_pwrdn", int'(STATE), 5);
        DBGKEEP = 1'b1;
        tick(1);
        chk("dbg_pwrup", int'(STATE), 6);
        DBGKEEP = 1'b0;
        tick(5);
        chk("dbg_pwrup_wait", int'(STATE), 6);
        HRESET = 1'b1;
        #1;
        chk("arst_STATE", int'(STATE), 0);
        chk("arst_HCLKEN", int'(HCLKEN), 1);
        chk("arst_ISOLATE", int'(ISOLATE), 0);
        chk("arst_SLEEPHOLDREQn", int'(SLEEPHOLDREQn), 1);
        chk("arst_PMUPWRDNREQ", int'(PMUPWRDNREQ), 0);

        // DBGKEEP held from reset inhibits any sleep entry.
        idle_inputs();
        DBGKEEP  = 1'b1;
        SLEEPING = 1'b1;
        tick(1);
        HRESET = 1'b0;
        tick(6);
        chk("dbgh_state", int'(STATE), 0);
        chk("dbgh_hclken", int'(HCLKEN), 1);
        idle_inputs();
        tick(1);

        // Randomised traffic against the model, with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            SLEEPING      = ($urandom_range(0, 9) < 8);
            SLEEPDEEP     = 1'($urandom_range(0, 1));
            SLEEPHOLDACKn = ($urandom_range(0, 3) != 0);
            WICDSACKn     = 1'($urandom_range(0, 1));
            WAKEUP        = ($urandom_range(0, 7) == 0);
            DBGKEEP       = ($urandom_range(0, 15) == 0);
            PMUPWRUPACK   = ($urandom_range(0, 3) == 0);
            HRESET        = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        HRESET = 1'b0;
        idle_inputs();
        tick(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
